// File: rtl/data_mem_cas_if.sv
// Request/response bundle for data_mem_cas: read, byte-enable write and CAS ports.
// The master drives requests; the memory (slave) drives data, strobes and busy.
interface data_mem_cas_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  cas_en;
  logic [ADDR_W-1:0]     cas_addr;
  logic                  cas_done;
  logic                  cas_swapped;
  logic                  cas_err;
  logic                  busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, cas_en, cas_addr,
    input  rd_data, rd_valid, cas_done, cas_swapped, cas_err, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, cas_en, cas_addr,
    output rd_data, rd_valid, cas_done, cas_swapped, cas_err, busy
  );
endinterface

// File: rtl/data_mem_cas.sv
// Data memory with separate read/write ports, write-first bypass, post-reset clear
// sequencer and an atomic compare-and-swap of adjacent words for the sort datapath.
module data_mem_cas #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  data_mem_cas_if.slave bus
);

  localparam int                NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CAS_LIM   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, CAS_CMP, CAS_WR} state_t;

  state_t              state_reg;
  logic                busy_reg;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic [ADDR_W-1:0]   cas_a_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_valid_reg;
  logic                cas_done_reg;
  logic                cas_swapped_reg;
  logic                cas_err_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                idle;
  logic                rd_in_range;
  logic                wr_in_range;
  logic                rd_accept;
  logic                wr_accept;
  logic                cas_legal;
  logic                bypass;
  logic                do_swap;
  logic [ADDR_W-1:0]   cas_b;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_merged;

  assign idle        = (state_reg == IDLE);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_X);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_X);
  assign cas_legal   = ({1'b0, bus.cas_addr} < CAS_LIM);
  // A CAS request in the same cycle claims the ports; reads/writes are dropped.
  assign rd_accept   = idle && bus.rd_en && !bus.cas_en;
  assign wr_accept   = idle && bus.wr_en && !bus.cas_en && wr_in_range;
  assign bypass      = wr_accept && (bus.wr_addr == bus.rd_addr);
  assign cas_b       = cas_a_reg + ADDR_W'(1);
  assign do_swap     = (state_reg == CAS_WR) && (lo_reg > hi_reg);
  assign rd_word     = rd_in_range ? mem[bus.rd_addr] : '0;

  // Write-first merge: bytes being written this cycle replace the stored bytes.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign rd_merged[gi*8 +: 8] = (bypass && bus.wr_be[gi]) ? bus.wr_data[gi*8 +: 8]
                                                              : rd_word[gi*8 +: 8];
    end
  endgenerate

  // Storage carries no reset; writes are suppressed while reset is held so an
  // aborted CAS never lands its second edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_reg == CLEAR) begin
        mem[clr_cnt_reg] <= '0;
      end else if (do_swap) begin
        mem[cas_a_reg] <= hi_reg;
        mem[cas_b]     <= lo_reg;
      end else if (wr_accept) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (bus.wr_be[b]) begin
            mem[bus.wr_addr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy_reg        <= (CLEAR_ON_RESET != 0);
      clr_cnt_reg     <= '0;
      cas_a_reg       <= '0;
      lo_reg          <= '0;
      hi_reg          <= '0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
      cas_done_reg    <= 1'b0;
      cas_swapped_reg <= 1'b0;
      cas_err_reg     <= 1'b0;
    end else begin
      rd_valid_reg    <= 1'b0;
      cas_done_reg    <= 1'b0;
      cas_swapped_reg <= 1'b0;
      cas_err_reg     <= 1'b0;
      case (state_reg)
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
          if (clr_cnt_reg == LAST_ADDR) begin
            clr_cnt_reg <= '0;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.cas_en) begin
            if (cas_legal) begin
              cas_a_reg <= bus.cas_addr;
              state_reg <= CAS_CMP;
              busy_reg  <= 1'b1;
            end else begin
              cas_done_reg <= 1'b1;
              cas_err_reg  <= 1'b1;
            end
          end
          if (rd_accept) begin
            rd_data_reg  <= rd_merged;
            rd_valid_reg <= 1'b1;
          end
        end
        CAS_CMP: begin
          lo_reg    <= mem[cas_a_reg];
          hi_reg    <= mem[cas_b];
          state_reg <= CAS_WR;
        end
        CAS_WR: begin
          cas_done_reg    <= 1'b1;
          cas_swapped_reg <= (lo_reg > hi_reg);
          state_reg       <= IDLE;
          busy_reg        <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data     = rd_data_reg;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.cas_done    = cas_done_reg;
  assign bus.cas_swapped = cas_swapped_reg;
  assign bus.cas_err     = cas_err_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_data_mem_cas.sv
// Directed bench for data_mem_cas: clear sequencer, byte writes with bypass,
// CAS swap/no-swap/error, request dropping, reset abort and a CAS-only bubble sort.
module tb_data_mem_cas;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  data_mem_cas_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_cas #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 0; bus.rd_addr = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
    bus.cas_en = 0; bus.cas_addr = '0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                         output logic valid);
    bus.rd_en = 1; bus.rd_addr = addr;
    tick();
    bus.rd_en = 0;
    data  = bus.rd_data;
    valid = bus.rd_valid;
    $display("read   addr=%0d data=%08h valid=%0b", addr, data, valid);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                          input logic [DATA_W-1:0] data);
    bus.wr_en = 1; bus.wr_addr = addr; bus.wr_be = be; bus.wr_data = data;
    tick();
    bus.wr_en = 0;
    $display("write  addr=%0d be=%04b data=%08h", addr, be, data);
  endtask

  task automatic do_cas(input logic [ADDR_W-1:0] addr, output int lat, output logic swapped,
                        output logic err, output logic busy_seen, output logic busy_end);
    bus.cas_en = 1; bus.cas_addr = addr;
    busy_seen = 0;
    tick();
    bus.cas_en = 0;
    lat = 1;
    while (!bus.cas_done && lat < 10) begin
      busy_seen |= bus.busy;
      tick();
      lat++;
    end
    swapped  = bus.cas_swapped;
    err      = bus.cas_err;
    busy_end = bus.busy;
    $display("cas    addr=%0d lat=%0d swapped=%0b err=%0b", addr, lat, swapped, err);
  endtask

  task automatic wait_clear(output int cycles, output logic strobe_seen);
    cycles = 0;
    strobe_seen = 0;
    while (bus.busy && cycles < 200) begin
      tick();
      cycles++;
      if (bus.busy) strobe_seen |= bus.rd_valid | bus.cas_done;
    end
    $display("clear  busy_cycles=%0d", cycles);
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic v, s;
    int cyc;
    logic [ADDR_W-1:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd17; addrs[2] = 5'd31;
    idle_inputs();
    rst_n = 0;
    repeat (3) tick();
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %08h expected 0", bus.rd_data); else pass_cnt++;
    total_cnt++; if ({bus.rd_valid, bus.cas_done, bus.cas_swapped, bus.cas_err} !== 4'b0)
      $display("FAIL reset_strobes: got %04b expected 0000", {bus.rd_valid, bus.cas_done, bus.cas_swapped, bus.cas_err}); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %0b expected 1", bus.busy); else pass_cnt++;
    rst_n = 1;
    wait_clear(cyc, s);
    total_cnt++; if (cyc !== 32) $display("FAIL clear_cycles: got %0d expected 32", cyc); else pass_cnt++;
    total_cnt++; if (s !== 1'b0) $display("FAIL clear_strobes: got %0b expected 0", s); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, v);
      total_cnt++; if (d !== 32'h0 || v !== 1'b1)
        $display("FAIL clear_read: addr %0d got %08h/%0b expected 00000000/1", addrs[i], d, v); else pass_cnt++;
    end
  endtask

  task automatic test_byte_write();
    logic [DATA_W-1:0] d;
    logic v;
    do_write(5'd3, 4'b1111, 32'hDEADBEEF);
    bus.wr_en = 1; bus.wr_addr = 5'd3; bus.wr_be = 4'b0001; bus.wr_data = 32'h000000AA;
    bus.rd_en = 1; bus.rd_addr = 5'd3;
    tick();
    bus.wr_en = 0; bus.rd_en = 0;
    $display("rdwr   addr=3 be=0001 data=000000AA rd_data=%08h", bus.rd_data);
    total_cnt++; if (bus.rd_data !== 32'hDEADBEAA || bus.rd_valid !== 1'b1)
      $display("FAIL bypass_merge: got %08h/%0b expected deadbeaa/1", bus.rd_data, bus.rd_valid); else pass_cnt++;
    do_read(5'd3, d, v);
    total_cnt++; if (d !== 32'hDEADBEAA) $display("FAIL byte_write: got %08h expected deadbeaa", d); else pass_cnt++;
    do_write(5'd3, 4'b0000, 32'h12345678);
    do_read(5'd3, d, v);
    total_cnt++; if (d !== 32'hDEADBEAA) $display("FAIL be_zero: got %08h expected deadbeaa", d); else pass_cnt++;
    do_write(5'd3, 4'b1010, 32'h11223344);
    do_read(5'd3, d, v);
    total_cnt++; if (d !== 32'h11AD33AA) $display("FAIL be_1010: got %08h expected 11ad33aa", d); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h11AD33AA)
      $display("FAIL rd_hold: got %08h/%0b expected 11ad33aa/0", bus.rd_data, bus.rd_valid); else pass_cnt++;
  endtask

  task automatic test_cas_swap();
    logic [DATA_W-1:0] d;
    logic v, sw, er, bs, be;
    int lat;
    do_write(5'd4, 4'b1111, 32'd456);
    do_write(5'd5, 4'b1111, 32'd1);
    do_cas(5'd4, lat, sw, er, bs, be);
    total_cnt++; if (lat !== 3) $display("FAIL cas_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++; if ({sw, er, bs, be} !== 4'b1010) $display("FAIL cas_flags: got %04b expected 1010", {sw, er, bs, be}); else pass_cnt++;
    do_read(5'd4, d, v);
    total_cnt++; if (d !== 32'd1) $display("FAIL cas_lo: got %0d expected 1", d); else pass_cnt++;
    do_read(5'd5, d, v);
    total_cnt++; if (d !== 32'd456) $display("FAIL cas_hi: got %0d expected 456", d); else pass_cnt++;
    do_cas(5'd4, lat, sw, er, bs, be);
    total_cnt++; if (lat !== 3 || sw !== 1'b0 || er !== 1'b0) $display("FAIL cas_noswap: got lat %0d sw %0b err %0b expected 3 0 0", lat, sw, er); else pass_cnt++;
    do_read(5'd4, d, v);
    total_cnt++; if (d !== 32'd1) $display("FAIL noswap_lo: got %0d expected 1", d); else pass_cnt++;
    do_read(5'd5, d, v);
    total_cnt++; if (d !== 32'd456) $display("FAIL noswap_hi: got %0d expected 456", d); else pass_cnt++;
    do_write(5'd6, 4'b1111, 32'd7);
    do_write(5'd7, 4'b1111, 32'd7);
    do_cas(5'd6, lat, sw, er, bs, be);
    total_cnt++; if (sw !== 1'b0) $display("FAIL cas_equal: got swapped %0b expected 0", sw); else pass_cnt++;
    tick();
    total_cnt++; if (bus.cas_done !== 1'b0 || bus.cas_swapped !== 1'b0)
      $display("FAIL cas_pulse: got done %0b sw %0b expected 0 0", bus.cas_done, bus.cas_swapped); else pass_cnt++;
  endtask

  task automatic test_cas_err();
    logic [DATA_W-1:0] d;
    logic v, sw, er, bs, be;
    int lat;
    do_write(5'd31, 4'b1111, 32'd5);
    do_write(5'd30, 4'b1111, 32'd9);
    do_cas(5'd31, lat, sw, er, bs, be);
    total_cnt++; if (lat !== 1) $display("FAIL err_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if ({sw, er, bs, be} !== 4'b0100) $display("FAIL err_flags: got %04b expected 0100", {sw, er, bs, be}); else pass_cnt++;
    do_read(5'd31, d, v);
    total_cnt++; if (d !== 32'd5) $display("FAIL err_mem31: got %0d expected 5", d); else pass_cnt++;
    do_read(5'd30, d, v);
    total_cnt++; if (d !== 32'd9) $display("FAIL err_mem30: got %0d expected 9", d); else pass_cnt++;
  endtask

  task automatic test_drop_during_cas();
    logic [DATA_W-1:0] d;
    logic v;
    bus.cas_en = 1; bus.cas_addr = 5'd4;
    bus.rd_en = 1; bus.rd_addr = 5'd4;
    bus.wr_en = 1; bus.wr_addr = 5'd10; bus.wr_be = 4'b1111; bus.wr_data = 32'h55;
    tick();
    bus.cas_en = 0;
    total_cnt++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL drop_n1: got valid %0b busy %0b expected 0 1", bus.rd_valid, bus.busy); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL drop_n2: got valid %0b expected 0", bus.rd_valid); else pass_cnt++;
    bus.rd_en = 0; bus.wr_en = 0;
    tick();
    $display("cas    addr=4 with rd/wr held done=%0b", bus.cas_done);
    total_cnt++; if (bus.rd_valid !== 1'b0 || bus.cas_done !== 1'b1)
      $display("FAIL drop_n3: got valid %0b done %0b expected 0 1", bus.rd_valid, bus.cas_done); else pass_cnt++;
    do_read(5'd10, d, v);
    total_cnt++; if (d !== 32'h0) $display("FAIL drop_write: got %08h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid_cas();
    logic [DATA_W-1:0] d;
    logic v, s;
    int cyc;
    do_write(5'd4, 4'b1111, 32'd9);
    do_write(5'd5, 4'b1111, 32'd2);
    do_read(5'd4, d, v);
    bus.cas_en = 1; bus.cas_addr = 5'd4;
    tick();
    bus.cas_en = 0;
    tick();
    rst_n = 0;
    #1;
    $display("reset  asserted during CAS_WR");
    total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL abort_rd_data: got %08h expected 0", bus.rd_data); else pass_cnt++;
    total_cnt++; if ({bus.rd_valid, bus.cas_done, bus.cas_swapped, bus.cas_err} !== 4'b0)
      $display("FAIL abort_strobes: got %04b expected 0000", {bus.rd_valid, bus.cas_done, bus.cas_swapped, bus.cas_err}); else pass_cnt++;
    repeat (2) tick();
    rst_n = 1;
    wait_clear(cyc, s);
    total_cnt++; if (cyc !== 32) $display("FAIL abort_clear: got %0d expected 32", cyc); else pass_cnt++;
    do_read(5'd4, d, v);
    total_cnt++; if (d !== 32'h0) $display("FAIL abort_mem4: got %0d expected 0", d); else pass_cnt++;
    do_read(5'd5, d, v);
    total_cnt++; if (d !== 32'h0) $display("FAIL abort_mem5: got %0d expected 0", d); else pass_cnt++;
  endtask

  task automatic test_bubble_sort();
    logic [DATA_W-1:0] d;
    logic v, sw, er, bs, be;
    int lat;
    int unsorted [10] = '{78, 456, 1, 89, 13, 56, 267, 102, 3, 51};
    int sorted   [10] = '{1, 3, 13, 51, 56, 78, 89, 102, 267, 456};
    for (int i = 0; i < 10; i++) do_write(ADDR_W'(i), 4'b1111, DATA_W'(unsorted[i]));
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < 9; i++) begin
        do_cas(ADDR_W'(i), lat, sw, er, bs, be);
        total_cnt++; if (lat !== 3 || er !== 1'b0) $display("FAIL sort_cas: pass %0d addr %0d got lat %0d err %0b expected 3 0", p, i, lat, er); else pass_cnt++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      do_read(ADDR_W'(i), d, v);
      total_cnt++; if (d !== DATA_W'(sorted[i])) $display("FAIL sort_result: addr %0d got %0d expected %0d", i, d, sorted[i]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_cas_swap();
    test_cas_err();
    test_drop_during_cas();
    test_reset_mid_cas();
    test_bubble_sort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_cas.md
Name: data_mem_cas

Overview:
- Parametrised successor to the single-port data memory used by the bubble-sort datapath.
- Separate synchronous read and write ports; byte-enable writes; write-first bypass on address collision.
- Post-reset hardware clear sequencer.
- Atomic compare-and-swap (CAS) of two adjacent words, so the sort inner loop swaps an out-of-order pair with one command instead of two loads, a compare and two stores.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words.
- ADDR_W, 5, address width; DEPTH <= 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents undefined, skip CLEAR.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request; accepted when busy=0.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read data; holds last value between reads.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- wr_en  in  1  write request; accepted when busy=0.
- wr_addr  in  ADDR_W  write word address.
- wr_be  in  DATA_W/8  byte enables; bit i covers byte i.
- wr_data  in  DATA_W  write data.
- cas_en  in  1  compare-and-swap request; accepted when busy=0.
- cas_addr  in  ADDR_W  CAS address a; operates on words a and a+1.
- cas_done  out  1  one-cycle pulse: CAS finished.
- cas_swapped  out  1  valid with cas_done: 1 = words were exchanged.
- cas_err  out  1  valid with cas_done: 1 = illegal address, no action.
- busy  out  1  high during CLEAR and CAS; all requests ignored while high.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_data=0, rd_valid=0, cas_done=0, cas_swapped=0, cas_err=0. State enters CLEAR if CLEAR_ON_RESET=1, else IDLE. busy=1 in CLEAR, 0 in IDLE.
- Reset asserted mid-CAS or mid-CLEAR aborts the operation immediately. A partially written CAS pair is permitted; the following CLEAR overwrites it.
- FSM states: CLEAR, IDLE, CAS_CMP, CAS_WR.
- CLEAR: counter 0..DEPTH-1 writes one zero word per cycle. Transitions to IDLE on the edge that writes word DEPTH-1. busy is high for exactly DEPTH cycles after rst_n rises.
- IDLE, priority: cas_en > {rd_en, wr_en}. rd_en and wr_en presented in the same cycle as an accepted cas_en are dropped, not queued.
- Read: accepted in cycle N; rd_data is valid and rd_valid=1 in cycle N+1.
- Write: memory updated at the edge ending cycle N, for enabled bytes only. wr_be=0 performs no write.
- Read and write in the same cycle are both serviced. If rd_addr==wr_addr, rd_data returns the merged word: new bytes where wr_be=1, old bytes elsewhere (write-first).
- Addresses >= DEPTH: reads return 0 with rd_valid; writes are discarded.
- CAS, cycle N (accept): if cas_addr >= DEPTH-1, no memory access; cas_done=1 and cas_err=1 in N+1; state stays IDLE; busy never asserts.
- Otherwise capture a, go to CAS_CMP (busy=1).
- CAS_CMP (N+1): read mem[a] and mem[a+1]; compare unsigned, full DATA_W.
- CAS_WR (N+2): if mem[a] > mem[a+1], write the swapped pair in this single edge and set cas_swapped=1; equal values are not swapped.
- CAS completion: cas_done pulses in N+3 with IDLE restored (busy=0). A new request is accepted in N+3.
- Outputs cas_swapped and cas_err are meaningful only while cas_done=1 and are 0 otherwise.
- rd_valid and cas_done are never asserted during CLEAR.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=32 -> busy high exactly 32 cycles. Subsequent reads of addresses 0, 17 and 31 each return 0 with rd_valid one cycle after rd_en.
- Write 0xDEADBEEF to addr 3 with wr_be=4'b1111. Then write 0x000000AA with wr_be=4'b0001, issuing a read of addr 3 in the same cycle -> rd_data=0xDEADBEAA on the read-during-write cycle.
- Preload mem[4]=456, mem[5]=1, then cas_en addr 4 -> cas_done in the 3rd cycle after accept with cas_swapped=1; mem[4]=1, mem[5]=456. Repeating the CAS on addr 4 -> cas_swapped=0, memory unchanged.
- cas_en addr 31 (DEPTH=32) -> cas_done+cas_err next cycle, busy never high, memory unchanged. rd_en raised during a legal CAS -> dropped, no rd_valid.
- Deassert rst_n during CAS_WR -> all outputs 0 immediately, CLEAR restarts on release, mem[4] and mem[5] read 0 afterwards.
- Full bubble sort of {78,456,1,89,13,56,267,102,3,51} driven only via CAS over addrs 0..8, repeated 9 passes -> memory reads {1,3,13,51,56,78,89,102,267,456}.
